reflect_seq_ctrl: RTL and testbench

Sequencer for the reflect-type output-path multiplexer. It runs a programmed number of reflect loops in the selected mode: 12 steps per loop in mode 0, 3 steps per loop in modes 1 and 2. For each step it waits for mux settling, hands one operation to the datapath under a valid/ready handshake, waits for completion, then advances the mux controller. It sits between the register/command layer and the 6:1 mux controller, and drives that controller's `ctrl_update`/`ctrl_reset` inputs and its mode.

---
 rtl/reflect_seq_ctrl.sv | 96 +++++++++
 tb/tb_reflect_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflect_seq_ctrl.sv
// reflect_seq_ctrl: runs programmed reflect loops, one datapath op per mux step, driving the mux controller
module reflect_seq_ctrl #(
    parameter int LOOP_W   = 8,
    parameter int SETTLE_W = 4
) (
    input  logic                SYS_CLK,
    input  logic                SYS_RST,
    input  logic                start_i,
    input  logic [3:0]          mode_i,
    input  logic [LOOP_W-1:0]   loop_num_i,
    input  logic [SETTLE_W-1:0] settle_i,
    input  logic                abort_i,
    input  logic                op_ready_i,
    input  logic                op_done_i,
    output logic [3:0]          mode_o,
    output logic                ctrl_reset_o,
    output logic                ctrl_update_o,
    output logic                op_valid_o,
    output logic [3:0]          step_o,
    output logic [LOOP_W-1:0]   loop_cnt_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);
    typedef enum logic [2:0] {IDLE, INIT, SETTLE, ISSUE, WAIT, ADV, DONE, ABORT} state_t;
    state_t state, state_nx;
    logic [LOOP_W-1:0] loop_num_q, loop_cnt_nx;
    logic [SETTLE_W-1:0] settle_q, settle_cnt;
    logic legal, last_step, abort_hit, go;
    assign legal = !mode_i[3] && (mode_i[2:0] == 3'b001 || mode_i[2:0] == 3'b010 || mode_i[2:0] == 3'b100);
    assign last_step = step_o == (mode_o[0] ? 4'd11 : 4'd2);
    assign loop_cnt_nx = loop_cnt_o + 1'b1;
    assign abort_hit = abort_i && state inside {INIT, SETTLE, ISSUE, WAIT, ADV};
    assign go = start_i && legal && loop_num_i != '0;
    // state register
    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // next-state logic and Moore output decode; abort overrides any handshake in the same cycle
    always_comb begin
        ctrl_reset_o  = state == INIT || state == ABORT;
        ctrl_update_o = state == ADV;
        op_valid_o    = state == ISSUE;
        busy_o        = state != IDLE;
        done_o        = state == DONE;
        state_nx      = state;
        case (state)
            IDLE:    state_nx = !start_i || !legal ? IDLE : (loop_num_i == '0 ? DONE : INIT);
            INIT:    state_nx = SETTLE;
            SETTLE:  state_nx = settle_cnt == '0 ? ISSUE : SETTLE;
            ISSUE:   state_nx = op_ready_i ? WAIT : ISSUE;
            WAIT:    state_nx = op_done_i ? ADV : WAIT;
            ADV:     state_nx = last_step && loop_cnt_nx == loop_num_q ? DONE : SETTLE;
            default: state_nx = IDLE;
        endcase
        if (abort_hit)
            state_nx = ABORT;
    end
    // latched run parameters, step shadow of the mux counter, loop count, settle countdown, error pulse
    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            mode_o     <= '0;
            loop_num_q <= '0;
            settle_q   <= '0;
            settle_cnt <= '0;
            step_o     <= '0;
            loop_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            err_o <= state == IDLE && start_i && !legal;
            case (state)
                IDLE: begin
                    if (go) begin
                        mode_o     <= mode_i;
                        loop_num_q <= loop_num_i;
                        settle_q   <= settle_i;
                        step_o     <= '0;
                        loop_cnt_o <= '0;
                    end
                end
                INIT:   settle_cnt <= settle_q;
                SETTLE: settle_cnt <= settle_cnt == '0 ? settle_cnt : settle_cnt - 1'b1;
                ADV: begin
                    settle_cnt <= settle_q;
                    step_o     <= last_step ? 4'd0 : step_o + 4'd1;
                    loop_cnt_o <= last_step ? loop_cnt_nx : loop_cnt_o;
                end
                ABORT:  step_o <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reflect_seq_ctrl.sv
// tb_reflect_seq_ctrl: start-decode vectors, directed corner sequences and randomized runs against a mux-counter model
module tb_reflect_seq_ctrl;
    localparam int LOOP_W = 8;
    localparam int SETTLE_W = 4;
    logic SYS_CLK = 0, SYS_RST = 1, start_i = 0, abort_i = 0, op_ready_i = 0, op_done_i = 0;
    logic [3:0] mode_i = 0;
    logic [LOOP_W-1:0] loop_num_i = 0;
    logic [SETTLE_W-1:0] settle_i = 0;
    logic [3:0] mode_o, step_o;
    logic ctrl_reset_o, ctrl_update_o, op_valid_o, busy_o, done_o, err_o;
    logic [LOOP_W-1:0] loop_cnt_o;
    int checks = 0, failures = 0;
    int mux_cnt = 0, hs_cnt = 0, upd_cnt = 0, rst_cnt = 0, done_cnt = 0, err_cnt = 0, gap = 0;
    int cur_last = 11, cur_settle = 0;
    logic [3:0] last_mode = 0;
    logic prev_valid = 0, prev_hs = 0, prev_abort = 0, accepted = 0, done_seen = 0, mon_hs = 0;
    int upd_steps[$];
    typedef struct {
        logic [3:0] mode;
        int         loops;
        logic       err;
        logic       busy;
        logic       done;
        logic       rst;
    } vec_t;

    reflect_seq_ctrl #(.LOOP_W(LOOP_W), .SETTLE_W(SETTLE_W)) dut (
        .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .start_i(start_i), .mode_i(mode_i),
        .loop_num_i(loop_num_i), .settle_i(settle_i), .abort_i(abort_i),
        .op_ready_i(op_ready_i), .op_done_i(op_done_i), .mode_o(mode_o),
        .ctrl_reset_o(ctrl_reset_o), .ctrl_update_o(ctrl_update_o), .op_valid_o(op_valid_o),
        .step_o(step_o), .loop_cnt_o(loop_cnt_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    function automatic void chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit legal_mode(input logic [3:0] m);
        return !m[3] && $countones(m[2:0]) == 1;
    endfunction

    // model of the mux controller counter plus per-cycle handshake protocol checks
    always @(negedge SYS_CLK) begin
        if (!SYS_RST) begin
            mux_cnt = 0;
            gap = 0;
            prev_valid = 0;
            prev_hs = 0;
            prev_abort = 0;
            accepted = 0;
            done_seen = 0;
        end else begin
            gap++;
            chk("step_mirror", step_o, mux_cnt);
            if (op_valid_o && !prev_valid) chk("settle_gap", gap, cur_settle + 2);
            if (prev_valid && !prev_hs && !prev_abort) chk("valid_hold", op_valid_o, 1);
            if (accepted && op_done_i && !abort_i) done_seen = 1;
            mon_hs = op_valid_o && op_ready_i && !abort_i;
            if (mon_hs) begin
                hs_cnt++;
                accepted = 1;
                done_seen = 0;
            end
            if (ctrl_update_o) begin
                chk("update_after_done", done_seen, 1);
                upd_steps.push_back(int'(step_o));
                upd_cnt++;
                accepted = 0;
                done_seen = 0;
                gap = 0;
                mux_cnt = mux_cnt == cur_last ? 0 : mux_cnt + 1;
            end
            if (ctrl_reset_o) begin
                rst_cnt++;
                mux_cnt = 0;
                accepted = 0;
                done_seen = 0;
                gap = 0;
            end
            done_cnt += int'(done_o);
            err_cnt += int'(err_o);
            prev_valid = op_valid_o;
            prev_hs = mon_hs;
            prev_abort = abort_i;
        end
    end

    task automatic do_start(input logic [3:0] m, input int loops, input int st);
        @(posedge SYS_CLK); #1;
        mode_i = m;
        loop_num_i = loops[LOOP_W-1:0];
        settle_i = st[SETTLE_W-1:0];
        start_i = 1;
        if (legal_mode(m) && loops != 0) begin
            cur_last = m[0] ? 11 : 2;
            cur_settle = st;
            last_mode = m;
        end
        @(posedge SYS_CLK); #1;
        start_i = 0;
        mode_i = 4'($urandom);
        loop_num_i = LOOP_W'($urandom);
        settle_i = SETTLE_W'($urandom);
    endtask

    task automatic run_seq(input logic [3:0] m, input int loops, input int st, input int ab_op,
                           input int phase, input int rdy_pct, input int dn_pct);
        int hs0, upd0, rst0, dn0, er0, s, total, cyc, ab_cyc, done_at, e_hs, e_upd;
        bit ab;
        hs0 = hs_cnt;
        upd0 = upd_cnt;
        rst0 = rst_cnt;
        dn0 = done_cnt;
        er0 = err_cnt;
        s = m[0] ? 12 : 3;
        total = loops * s;
        upd_steps.delete();
        do_start(m, loops, st);
        ab = 0;
        cyc = 0;
        ab_cyc = -1;
        done_at = -1;
        while (busy_o && cyc < 3000) begin
            if (done_o) done_at = cyc + 1;
            op_ready_i = $urandom_range(99) < rdy_pct;
            op_done_i = $urandom_range(99) < dn_pct;
            abort_i = 0;
            if (!ab && ab_op >= 0 && phase == 0 && hs_cnt - hs0 == ab_op + 1) begin
                abort_i = 1;
                op_done_i = 1;
                ab = 1;
                ab_cyc = cyc;
            end
            if (!ab && ab_op >= 0 && phase == 1 && hs_cnt - hs0 == ab_op && op_valid_o) begin
                abort_i = 1;
                op_ready_i = 1;
                ab = 1;
                ab_cyc = cyc;
            end
            @(posedge SYS_CLK); #1;
            cyc++;
        end
        op_ready_i = 0;
        op_done_i = 0;
        abort_i = 0;
        e_hs = ab_op < 0 ? total : ab_op + (phase == 0 ? 1 : 0);
        e_upd = ab_op < 0 ? total : ab_op;
        chk("run_finished", busy_o, 0);
        chk("handshakes", hs_cnt - hs0, e_hs);
        chk("updates", upd_cnt - upd0, e_upd);
        chk("ctrl_resets", rst_cnt - rst0, ab_op < 0 ? 1 : 2);
        chk("done_pulses", done_cnt - dn0, ab_op < 0 ? 1 : 0);
        chk("err_pulses", err_cnt - er0, 0);
        chk("loop_cnt", loop_cnt_o, e_upd / s);
        chk("step_end", step_o, 0);
        for (int i = 0; i < upd_steps.size(); i++) chk("update_step", upd_steps[i], i % s);
        if (ab_op >= 0) chk("abort_to_idle", cyc - ab_cyc, 2);
        else if (rdy_pct >= 100 && dn_pct >= 100) chk("done_cycle", done_at, total * (st + 4) + 2);
        if (busy_o) begin
            SYS_RST = 0;
            #2;
            SYS_RST = 1;
        end
    endtask

    initial begin
        vec_t vecs[10];
        int n, u0, d0, cyc, loops, s, ab_op;
        logic [3:0] m;
        vecs[0] = '{4'b0011, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b1001, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'b0000, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'b1000, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'b0111, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{4'b0001, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{4'b0100, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{4'b0001, 3, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{4'b0010, 1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{4'b0100, 200, 1'b0, 1'b1, 1'b0, 1'b1};
        #1 SYS_RST = 0;
        #11;
        chk("reset_outputs", {mode_o, ctrl_reset_o, ctrl_update_o, op_valid_o, step_o, loop_cnt_o, busy_o, done_o, err_o}, 0);
        @(posedge SYS_CLK); #1;
        SYS_RST = 1;
        repeat (2) @(posedge SYS_CLK);
        #1;
        chk("idle_after_reset", busy_o, 0);
        foreach (vecs[i]) begin
            do_start(vecs[i].mode, vecs[i].loops, 1);
            chk($sformatf("vec%0d_err", i), err_o, vecs[i].err);
            chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].busy);
            chk($sformatf("vec%0d_done", i), done_o, vecs[i].done);
            chk($sformatf("vec%0d_ctrl_reset", i), ctrl_reset_o, vecs[i].rst);
            abort_i = 1;
            @(posedge SYS_CLK); #1;
            abort_i = 0;
            repeat (2) @(posedge SYS_CLK);
            #1;
            chk($sformatf("vec%0d_back_idle", i), {busy_o, err_o}, 0);
            chk($sformatf("vec%0d_mode_latch", i), mode_o, last_mode);
        end
        run_seq(4'b0001, 1, 0, -1, 0, 100, 100);
        run_seq(4'b0100, 2, 3, -1, 0, 100, 100);
        u0 = upd_cnt;
        d0 = done_cnt;
        do_start(4'b0010, 1, 1);
        op_ready_i = 0;
        op_done_i = 0;
        @(posedge SYS_CLK); #1;
        op_done_i = 1;
        @(posedge SYS_CLK); #1;
        op_done_i = 0;
        @(posedge SYS_CLK); #1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            n += int'(op_valid_o);
            op_ready_i = i == 5;
            @(posedge SYS_CLK); #1;
        end
        op_ready_i = 0;
        chk("valid_hold_cycles", n, 6);
        chk("valid_after_hs", op_valid_o, 0);
        repeat (3) @(posedge SYS_CLK);
        #1;
        chk("no_update_without_done", upd_cnt - u0, 0);
        op_done_i = 1;
        @(posedge SYS_CLK); #1;
        chk("update_after_op_done", ctrl_update_o, 1);
        op_ready_i = 1;
        for (cyc = 0; busy_o && cyc < 200; cyc++) begin
            @(posedge SYS_CLK); #1;
        end
        op_ready_i = 0;
        op_done_i = 0;
        chk("held_seq_finished", busy_o, 0);
        chk("held_seq_done", done_cnt - d0, 1);
        chk("held_seq_updates", upd_cnt - u0, 3);
        chk("held_seq_loop_cnt", loop_cnt_o, 1);
        run_seq(4'b0001, 1, 0, 5, 0, 100, 100);
        run_seq(4'b0001, 1, 0, -1, 0, 100, 100);
        run_seq(4'b0010, 2, 1, 2, 1, 100, 100);
        do_start(4'b0100, 3, 2);
        op_ready_i = 0;
        for (cyc = 0; !op_valid_o && cyc < 50; cyc++) begin
            @(posedge SYS_CLK); #1;
        end
        chk("reached_issue", op_valid_o, 1);
        #2;
        SYS_RST = 0;
        #1;
        chk("async_reset_outputs", {mode_o, ctrl_reset_o, ctrl_update_o, op_valid_o, step_o, loop_cnt_o, busy_o, done_o, err_o}, 0);
        @(posedge SYS_CLK); #1;
        SYS_RST = 1;
        repeat (2) @(posedge SYS_CLK);
        #1;
        chk("idle_after_release", {busy_o, ctrl_reset_o, ctrl_update_o, done_o}, 0);
        run_seq(4'b0100, 1, 2, -1, 0, 100, 100);
        repeat (15) begin
            m = 4'b0001 << $urandom_range(2);
            loops = int'($urandom_range(3, 1));
            s = m[0] ? 12 : 3;
            ab_op = $urandom_range(2) == 0 ? int'($urandom_range(loops * s - 1)) : -1;
            run_seq(m, loops, int'($urandom_range(3)), ab_op, int'($urandom_range(1)),
                    int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
